pipe_skid_reg: RTL
==================

Name: pipe_skid_reg

Overview:
- Parametrised successor to the fixed IF/ID-style pipeline register: a two-entry elastic pipeline stage (main register plus skid register) with a valid/ready handshake, flush-to-bubble and saturating performance counters.
- Sits between any two pipeline stages. Control and payload fields are packed into two buses.
- Lets the core stall downstream without a combinational ready path back upstream.
- Lets a stage be squashed on branch or hazard by clearing only its control fields.

Parameters:
- DATA_W, 96: payload width (pc, inst, operands etc.), not cleared on flush.
- CTRL_W, 16: control-field width (RegWrite, MemToReg, we, re, ...), forced to 0 on flush.
- CNT_W, 16: width of the performance counters.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- flush  in  1  squash all held entries this cycle
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept; registered, depends only on skid occupancy
- in_ctrl  in  CTRL_W  upstream control bits
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  main register holds a valid entry
- out_ready  in  1  downstream accepts the entry this cycle
- out_ctrl  out  CTRL_W  main-register control bits
- out_data  out  DATA_W  main-register payload
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
- bubble_cnt  out  CNT_W  cycles with out_valid=0

Behaviour:
- One clock domain. Reset is synchronous, active-low (reset_n sampled on the rising edge of clock); it has priority over everything.
- Reset values:
  - out_valid=0, out_ctrl=0, out_data=0.
  - skid valid=0, skid ctrl/data=0.
  - in_ready=1.
  - stall_cnt=0, bubble_cnt=0.
- Handshake definitions:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - in_ready = !skid_valid, driven from a flop with no combinational path from out_ready.
- States, encoded by {main valid, skid valid}:
  - EMPTY: in_ready=1, out_valid=0.
  - ONE: in_ready=1, out_valid=1.
  - FULL: in_ready=0, out_valid=1.
- Transitions, when flush=0:
  - EMPTY, input transfer -> ONE; main <= in.
  - EMPTY, no input -> stays EMPTY.
  - ONE, input and output transfer -> ONE; main <= in.
  - ONE, input transfer, no output -> FULL; skid <= in, main unchanged.
  - ONE, output transfer, no input -> EMPTY.
  - ONE, neither -> hold.
  - FULL, output transfer -> ONE; main <= skid, skid cleared.
  - FULL, no output -> hold.
  - FULL, in_valid is ignored.
- Latency and ordering:
  - 1 cycle from input transfer to out_valid when EMPTY.
  - Entries leave in strict arrival order.
  - Nothing is dropped or duplicated.
- Flush=1, at the next edge:
  - main and skid both invalid; out_ctrl=0; skid ctrl=0.
  - out_data and skid data hold their old values.
  - State becomes EMPTY and in_ready=1.
  - Any input or output transfer presented in the flush cycle is discarded; flush beats a simultaneous in_valid.
  - Counters are not affected by flush.
- Stalled stage: out_ctrl and out_data are stable while out_valid & !out_ready.
- Counters:
  - Each edge (reset_n=1): stall_cnt += 1 if out_valid & !out_ready; bubble_cnt += 1 if !out_valid.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - Only reset clears them.
- Reset asserted mid-operation: all entries are lost; state is EMPTY on the next edge, regardless of in_valid, out_ready or flush.

Test Plan:
- Reset, then hold reset_n=0 for 2 cycles -> out_valid=0, in_ready=1, out_ctrl=0, out_data=0, both counters 0.
- Streaming: out_ready=1, push data 1..8 (ctrl=0x00FF) on consecutive cycles -> out_data 1..8 each 1 cycle later, in_ready stays 1, stall_cnt=0.
- Backpressure: push A=0x11, B=0x22, C=0x33 with out_ready=0:
  - Expected: A in main, B in skid, in_ready=0 from the cycle after B; C held upstream.
  - Then raise out_ready -> outputs in order A, B, C; stall_cnt equals the stalled cycles (e.g. 3).
- Flush in FULL with ctrl=0xFFFF in main and skid -> next cycle out_valid=0, out_ctrl=0, in_ready=1; a simultaneous in_valid entry is not output.
- Saturation with CNT_W=4: idle 20 cycles after reset -> bubble_cnt reaches 15 and holds.
- Reset mid-stall in FULL -> next cycle EMPTY, in_ready=1, counters 0.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline stage (main + skid register) with valid/ready handshake,
// control-only flush and saturating stall/bubble counters.
module pipe_skid_reg #(
    parameter int unsigned DATA_W = 96,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Encoding is {main valid, skid valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic in_xfer;
    logic out_xfer;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;
    logic clear_skid;

    assign out_valid = (state != EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        clear_skid     = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    load_main_in = 1'b1;
                end else if (in_xfer) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (out_xfer) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                    clear_skid     = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // in_ready is its own flop so out_ready never reaches upstream combinationally.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_ctrl  <= '0;
            out_data  <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (flush) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_ctrl  <= '0;
            skid_ctrl <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != FULL);
            if (load_main_in) begin
                out_ctrl <= in_ctrl;
                out_data <= in_data;
            end else if (load_main_skid) begin
                out_ctrl <= skid_ctrl;
                out_data <= skid_data;
            end
            if (load_skid) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end else if (clear_skid) begin
                skid_ctrl <= '0;
                skid_data <= '0;
            end
        end
    end

    // Counters ignore flush; only reset clears them.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (!out_valid && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_ONE;
            end
        end
    end

endmodule
